firdec: RTL and testbench
=========================

Name: firdec

Overview:
- Decimating output stage that sits directly downstream of the direct-form FIR block and consumes its accumulator-width result stream.
- Keeps one of every M input samples.
- Scales each kept sample by an arithmetic right shift with optional rounding, then saturates it to the output width.
- Buffers kept samples in a small FIFO behind a valid/ready handshake, so a stalling consumer never back-pressures the FIR.

Parameters:
ACCW, 16, input (FIR accumulator) width in bits
OW, 8, output sample width in bits; OW <= ACCW
M, 4, decimation factor; M >= 1; M = 1 keeps every sample
SHIFT, 4, arithmetic right shift applied before saturation; 0 <= SHIFT < ACCW
DEPTH, 4, output FIFO depth; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
clear  input  1  synchronous active-high reset
in_valid  input  1  in_data carries a new FIR output this cycle
in_data  input  ACCW  signed FIR output sample
out_valid  output  1  FIFO non-empty; out_data is valid
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  OW  signed decimated sample at FIFO head
ovf  output  1  sticky: a kept sample was dropped because the FIFO was full
sat  output  1  sticky: at least one kept sample was saturated

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset clear.
- On clear:
  - phase counter = 0.
  - FIFO emptied.
  - out_valid = 0, out_data = 0, ovf = 0, sat = 0.
  - clear overrides every other input in the same cycle.
- Phase counter:
  - Width clog2(M), minimum 1.
  - Increments on every in_valid cycle; wraps from M-1 to 0.
  - A sample is kept when in_valid = 1 and phase = 0, so the first sample after clear is always kept.
  - In-flight state is discarded by clear mid-operation; the next sample after clear is kept.
- Scaling (combinational on in_data, evaluated in ACCW+1 bits to avoid overflow):
  - With rounding: r = (in_data + 2^(SHIFT-1)) >>> SHIFT. When SHIFT = 0, r = in_data.
  - Saturation: if r > 2^(OW-1)-1, output 2^(OW-1)-1; if r < -2^(OW-1), output -2^(OW-1); otherwise output r truncated to OW bits.
  - Any clamp on a kept sample sets sat.
- FIFO:
  - DEPTH entries, pointers and count registered.
  - Push = kept sample. Pop = out_valid & out_ready.
  - Latency: a sample kept at edge t is visible on out_data/out_valid after edge t (one cycle) when the FIFO was empty.
  - out_data always shows the head entry. It holds its last value when the FIFO is empty (0 after clear).
  - Full, push and no pop: the new sample is dropped, ovf is set, FIFO contents are unchanged.
  - Full, push and pop in the same cycle: both happen; nothing is dropped and ovf is not set.
  - Empty, pop: impossible, because out_valid = 0.
  - Empty, push: out_valid rises next cycle.
- Flags: ovf and sat stay set until clear.
- No combinational path from in_* to out_*. out_ready affects only state.

Optional Feature:
- FIRDEC_ROUND_EN defined: round-half-up as specified, by adding 2^(SHIFT-1) before the shift.
- Undefined: truncation toward minus infinity, r = in_data >>> SHIFT, with no adder.
- Saturation, sat and all other behaviour are identical in both builds.

Decomposition:
- Shared package firdec_pkg holds:
  - a clog2 constant function.
  - the saturate(value, OW) function.
  - OW-derived constants for the max and min saturated values.
- One sub-module is natural: firdec_fifo, a generic synchronous FIFO with parameters DW and DEPTH.
  - Ports: clk, clear, push, din, pop, dout, empty, full.
  - firdec instantiates it with DW = OW.
  - It reports full without blocking; firdec gates the push and sets ovf.

Test Plan (ACCW=16, OW=8, M=4, SHIFT=4, DEPTH=4, out_ready=1 unless stated):
1. Decimation: clear, then in_data 0x0100,0x0001,0x0002,0x0003,0x0200 on consecutive valid cycles -> out_data 0x10 then 0x20; out_valid pulses one cycle after the 1st and 5th inputs; sat=0, ovf=0.
2. Rounding: kept inputs 24, 23, -24 -> with FIRDEC_ROUND_EN 2, 1, -1; without it 1, 1, -2.
3. Saturation: kept inputs 0x7FF0, 0x8000, 0x07E0 -> 127, -128, 126; sat=1 after the first and stays 1.
4. FIFO full: out_ready=0, feed 20 valid inputs 16..35 (5 kept: 16,20,24,28,32 -> scaled 1,1,2,2,2 with rounding) -> out_valid=1, ovf=1 after the 5th kept sample; raising out_ready drains exactly 4 entries in order 1,1,2,2.
5. Full with simultaneous pop: fill 4 entries, then in the same cycle present a kept sample and out_ready=1 -> no drop, ovf=0, count stays 4, new sample appears last in the drain order.
6. Clear mid-operation: after 2 inputs (phase=2) with 3 entries buffered, ovf=1, sat=1, assert clear for one cycle, also with in_valid=1 -> out_valid=0, out_data=0, flags 0, and the next valid input is kept.

Source files
------------

// File: rtl/firdec_pkg.sv
// -----------------------------------------------------------------------------
// firdec_pkg
// Shared helpers for the FIR decimating output stage:
//   - clog2 / clog2_min1 : constant functions for sizing counters and pointers
//   - sat_max / sat_min  : largest and smallest signed value of an OW-bit word
//   - saturate           : clamps a wide signed value into an OW-bit range and
//                          reports whether a clamp happened
// -----------------------------------------------------------------------------
package firdec_pkg;

    // Working width of the generic saturation helper; callers sign-extend
    // into it and truncate the result back to their own output width.
    localparam int unsigned SAT_W = 64;

    // Result of a saturation: the (possibly clamped) value plus a clamp flag.
    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    clamped;
    } sat_res_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 32'd0;
        v = 32'd1;
        while (v < n) begin
            v = v << 1;
            r = r + 32'd1;
        end
        return r;
    endfunction

    // Ceiling log2 but never below one bit, for counters that must exist
    // even when they only ever hold zero.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = clog2(n);
        if (r < 32'd1) begin
            r = 32'd1;
        end
        return r;
    endfunction

    // Largest signed value representable in ow bits.
    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned ow);
        return (64'sd1 <<< (ow - 32'd1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in ow bits.
    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned ow);
        return -(64'sd1 <<< (ow - 32'd1));
    endfunction

    // Clamp value into the signed ow-bit range.
    function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] value,
                                          input int unsigned ow);
        sat_res_t                res;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = sat_max(ow);
        lo = sat_min(ow);
        if (value > hi) begin
            res.value   = hi;
            res.clamped = 1'b1;
        end else if (value < lo) begin
            res.value   = lo;
            res.clamped = 1'b1;
        end else begin
            res.value   = value;
            res.clamped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/firdec_if.sv
// -----------------------------------------------------------------------------
// firdec_if
// Streaming bus of the decimating output stage.
//   in_valid / in_data   : FIR accumulator stream (no back-pressure)
//   out_valid / out_ready / out_data : decimated, scaled sample stream
// Modports:
//   master : the environment side (drives the FIR stream and out_ready)
//   slave  : the firdec side
// -----------------------------------------------------------------------------
interface firdec_if #(
    parameter int ACCW = 16,
    parameter int OW   = 8
);
    logic                   in_valid;
    logic signed [ACCW-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [OW-1:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/firdec_fifo.sv
// -----------------------------------------------------------------------------
// firdec_fifo
// Generic synchronous FIFO with a registered head output.
// Parameters: DW (data width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous active-high reset (empties FIFO, dout = 0)
//   push  : write din (ignored when full unless a pop happens this cycle)
//   din   : write data
//   pop   : remove the head entry (ignored when empty)
//   dout  : head entry; holds its last value while empty
//   empty : no entries stored
//   full  : DEPTH entries stored
// -----------------------------------------------------------------------------
module firdec_fifo
    import firdec_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [DW-1:0] dout_r;
    logic          empty_r;
    logic          full_r;

    logic          push_ok_s;
    logic          pop_ok_s;
    logic [AW-1:0] wr_ptr_next_s;
    logic [AW-1:0] rd_ptr_next_s;
    logic [CW-1:0] count_next_s;
    logic [DW-1:0] head_next_s;

    // Next-state for pointers, count and the registered head word.
    always_comb begin
        pop_ok_s      = pop & ~empty_r;
        // A pop in the same cycle frees a slot, so a full FIFO may still accept.
        push_ok_s     = push & (~full_r | pop_ok_s);
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = dout_r;

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        if (push_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_ok_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // The head register mirrors the entry at the next read pointer. When
        // the incoming word becomes the only entry it is not in memory yet,
        // so it is forwarded straight from din.
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = dout_r;
        end else if (push_ok_s && (count_r == (pop_ok_s ? CW'(1) : CW'(0)))) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Pointer, count, status and head registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            dout_r   <= {DW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            dout_r   <= head_next_s;
            empty_r  <= (count_next_s == {CW{1'b0}});
            full_r   <= (count_next_s == FULL_CNT);
        end
    end

    // Storage array; stale contents are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = dout_r;
    assign empty = empty_r;
    assign full  = full_r;

endmodule

// File: rtl/firdec.sv
// -----------------------------------------------------------------------------
// firdec
// Decimating output stage behind a direct-form FIR. Keeps one of every M
// input samples, scales it by an arithmetic right shift of SHIFT bits,
// saturates it to OW bits and queues it in a DEPTH-entry FIFO. The FIR side
// is never back-pressured: a kept sample arriving at a full FIFO is dropped.
//
// Build option:
//   FIRDEC_ROUND_EN defined   : round half up (add 2^(SHIFT-1) before shift)
//   FIRDEC_ROUND_EN undefined : plain truncation toward minus infinity
//
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous active-high reset, overrides all other inputs
//   bus   : firdec_if slave (in_valid, in_data, out_valid, out_ready, out_data)
//   ovf   : sticky, a kept sample was dropped on a full FIFO
//   sat   : sticky, a kept sample was clamped
// -----------------------------------------------------------------------------
module firdec
    import firdec_pkg::*;
#(
    parameter int ACCW  = 16,
    parameter int OW    = 8,
    parameter int M     = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     clear,
    firdec_if.slave  bus,
    output logic     ovf,
    output logic     sat
);

    localparam int PW = clog2_min1(M);
    localparam logic [PW-1:0] PHASE_LAST = PW'(M - 1);

    logic [PW-1:0]        phase_r;
    logic                 ovf_r;
    logic                 sat_r;

    logic                 keep_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 full_s;
    logic [OW-1:0]        fifo_dout_s;

    logic signed [ACCW:0] ext_s;
    logic signed [ACCW:0] biased_s;
    logic signed [ACCW:0] shifted_s;
    sat_res_t             sat_res_s;
    logic [OW-1:0]        scaled_s;
    logic                 clamped_s;

    assign keep_s = bus.in_valid & (phase_r == {PW{1'b0}});

    // Phase counter: counts valid inputs modulo M; phase 0 marks a kept sample.
    always_ff @(posedge clk) begin
        if (clear) begin
            phase_r <= {PW{1'b0}};
        end else if (bus.in_valid) begin
            if (phase_r == PHASE_LAST) begin
                phase_r <= {PW{1'b0}};
            end else begin
                phase_r <= phase_r + PW'(1);
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // One guard bit so the rounding bias can never wrap the sum.
    assign ext_s = $signed({bus.in_data[ACCW-1], bus.in_data});

`ifdef FIRDEC_ROUND_EN
    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACCW:0] HALF_LSB = (ACCW + 1)'(1) <<< (SHIFT - 1);
        assign biased_s = ext_s + HALF_LSB;
    end else begin : g_no_round
        assign biased_s = ext_s;
    end
`else
    assign biased_s = ext_s;
`endif

    assign shifted_s = biased_s >>> SHIFT;

    // Clamp the scaled value to the output range and flag any clamp.
    always_comb begin
        sat_res_s = saturate(64'(shifted_s), OW);
        scaled_s  = OW'(sat_res_s.value);
        clamped_s = sat_res_s.clamped;
    end

    assign pop_s  = ~empty_s & bus.out_ready;
    assign push_s = keep_s & (~full_s | pop_s);

    firdec_fifo #(
        .DW    (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (push_s),
        .din   (scaled_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .empty (empty_s),
        .full  (full_s)
    );

    // Sticky status flags, cleared only by clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            ovf_r <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (keep_s & full_s & ~pop_s);
            sat_r <= sat_r | (keep_s & clamped_s);
        end
    end

    assign bus.out_valid = ~empty_s;
    assign bus.out_data  = fifo_dout_s;
    assign ovf           = ovf_r;
    assign sat           = sat_r;

endmodule

// File: tb/tb_firdec.sv
// -----------------------------------------------------------------------------
// tb_firdec
// Self-checking bench for firdec (ACCW=16, OW=8, M=4, SHIFT=4, DEPTH=4).
// A queue-based model predicts out_valid/out_data/ovf/sat each cycle; directed
// sequences add literal expectations, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_firdec;

    localparam int ACCW  = 16;
    localparam int OW    = 8;
    localparam int M     = 4;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    logic ovf;
    logic sat;

    firdec_if #(.ACCW(ACCW), .OW(OW)) bus ();

    firdec #(
        .ACCW  (ACCW),
        .OW    (OW),
        .M     (M),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus),
        .ovf   (ovf),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q[$];
    int m_count = 0;     // valid inputs since clear
    int m_head  = 0;
    bit m_ovf   = 1'b0;
    bit m_sat   = 1'b0;
    bit chk_en  = 1'b0;

    function automatic int floor_div(input int a, input int b);
        int r;
        r = a / b;
        if ((a % b) != 0 && a < 0) r = r - 1;
        return r;
    endfunction

    function automatic int model_scale(input int x, output bit clamped);
        int b;
        int r;
        int hi;
        int lo;
        hi = (1 << (OW - 1)) - 1;
        lo = -(1 << (OW - 1));
        b  = x;
`ifdef FIRDEC_ROUND_EN
        if (SHIFT > 0) b = x + (1 << (SHIFT - 1));
`endif
        r = floor_div(b, 1 << SHIFT);
        clamped = 1'b0;
        if (r > hi) begin r = hi; clamped = 1'b1; end
        if (r < lo) begin r = lo; clamped = 1'b1; end
        return r;
    endfunction

    // Compare outputs of the last edge, then advance the model with the
    // inputs that the coming edge will sample.
    always @(negedge clk) begin
        bit pop_m;
        bit keep_m;
        bit clamp_m;
        int s;
        if (chk_en) begin
            chk("cmp_out_valid", int'(bus.out_valid), (q.size() > 0) ? 1 : 0);
            chk("cmp_out_data", int'(bus.out_data), m_head);
            chk("cmp_ovf", int'(ovf), int'(m_ovf));
            chk("cmp_sat", int'(sat), int'(m_sat));
        end
        if (clear) begin
            q.delete();
            m_count = 0;
            m_head  = 0;
            m_ovf   = 1'b0;
            m_sat   = 1'b0;
            chk_en  = 1'b1;
        end else begin
            pop_m  = (q.size() > 0) && (bus.out_ready === 1'b1);
            keep_m = (bus.in_valid === 1'b1) && ((m_count % M) == 0);
            if (bus.in_valid === 1'b1) m_count = m_count + 1;
            if (pop_m) void'(q.pop_front());
            if (keep_m) begin
                s = model_scale(int'(bus.in_data), clamp_m);
                if (clamp_m) m_sat = 1'b1;
                if (q.size() < DEPTH) q.push_back(s);
                else m_ovf = 1'b1;
            end
            if (q.size() > 0) m_head = q[0];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        bus.in_valid = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic keep_feed(input logic [15:0] d);
        feed(d);
        repeat (M - 1) feed(16'h0000);
    endtask

    task automatic drain(output int got[$]);
        got.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && bus.out_valid === 1'b1; k++) begin
            got.push_back(int'(bus.out_data));
            step();
        end
    endtask

    logic [15:0] d2 [3];
    logic [15:0] d3 [3];
    int          e2 [3];
    int          e3 [3];
    int          e4 [4];
    int          e5 [4];
    int          got[$];
    int          rnd;
    logic [15:0] rd;
    int          ready_pct;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b1;
        clear         = 1'b1;
        step();
        step();
        clear = 1'b0;

        // 1. decimation
        do_clear();
        chk("t1_reset_valid", int'(bus.out_valid), 0);
        chk("t1_reset_data", int'(bus.out_data), 0);
        chk("t1_reset_ovf", int'(ovf), 0);
        chk("t1_reset_sat", int'(sat), 0);
        feed(16'h0100);
        chk("t1_first_valid", int'(bus.out_valid), 1);
        chk("t1_first_data", int'(bus.out_data), 16);
        feed(16'h0001);
        chk("t1_valid_pulse", int'(bus.out_valid), 0);
        chk("t1_data_hold", int'(bus.out_data), 16);
        feed(16'h0002);
        feed(16'h0003);
        feed(16'h0200);
        chk("t1_second_valid", int'(bus.out_valid), 1);
        chk("t1_second_data", int'(bus.out_data), 32);
        step();
        chk("t1_idle_valid", int'(bus.out_valid), 0);
        chk("t1_sat", int'(sat), 0);
        chk("t1_ovf", int'(ovf), 0);

        // 2. rounding
        d2 = '{16'd24, 16'd23, 16'hFFE8};
`ifdef FIRDEC_ROUND_EN
        e2 = '{2, 1, -1};
`else
        e2 = '{1, 1, -2};
`endif
        do_clear();
        for (int i = 0; i < 3; i++) begin
            feed(d2[i]);
            chk("t2_round_data", int'(bus.out_data), e2[i]);
            repeat (M - 1) feed(16'h0000);
        end
        chk("t2_sat", int'(sat), 0);

        // 3. saturation
        d3 = '{16'h7FF0, 16'h8000, 16'h07E0};
        e3 = '{127, -128, 126};
        do_clear();
        for (int i = 0; i < 3; i++) begin
            feed(d3[i]);
            chk("t3_sat_data", int'(bus.out_data), e3[i]);
            chk("t3_sat_flag", int'(sat), 1);
            repeat (M - 1) feed(16'h0000);
        end

        // 4. FIFO full with a stalled consumer
`ifdef FIRDEC_ROUND_EN
        e4 = '{1, 1, 2, 2};
`else
        e4 = '{1, 1, 1, 1};
`endif
        do_clear();
        bus.out_ready = 1'b0;
        for (int v = 16; v <= 35; v++) begin
            feed(16'(v));
            if (v == 31) chk("t4_ovf_before_drop", int'(ovf), 0);
            if (v == 32) chk("t4_ovf_on_drop", int'(ovf), 1);
        end
        chk("t4_valid", int'(bus.out_valid), 1);
        drain(got);
        chk("t4_drain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_drain_data", got[i], e4[i]);

        // 5. full FIFO with simultaneous push and pop
        e5 = '{32, 48, 64, 80};
        do_clear();
        bus.out_ready = 1'b0;
        keep_feed(16'h0100);
        keep_feed(16'h0200);
        keep_feed(16'h0300);
        keep_feed(16'h0400);
        chk("t5_full_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        feed(16'h0500);
        chk("t5_no_ovf", int'(ovf), 0);
        drain(got);
        chk("t5_drain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t5_drain_data", got[i], e5[i]);

        // 6. clear in the middle of operation
        do_clear();
        bus.out_ready = 1'b0;
        keep_feed(16'h7FF0);
        keep_feed(16'h0100);
        keep_feed(16'h0200);
        keep_feed(16'h0300);
        feed(16'h0400);
        feed(16'h0000);
        chk("t6_pre_ovf", int'(ovf), 1);
        chk("t6_pre_sat", int'(sat), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7FF0;
        step();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_clr_valid", int'(bus.out_valid), 0);
        chk("t6_clr_data", int'(bus.out_data), 0);
        chk("t6_clr_ovf", int'(ovf), 0);
        chk("t6_clr_sat", int'(sat), 0);
        feed(16'h0300);
        chk("t6_kept_valid", int'(bus.out_valid), 1);
        chk("t6_kept_data", int'(bus.out_data), 48);

        // randomized traffic
        bus.out_ready = 1'b1;
        ready_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 500) == 0) ready_pct = int'($urandom_range(10, 95));
            bus.in_valid = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rd = 16'($urandom);
            end else begin
                rnd = int'($urandom_range(0, 4095)) - 2048;
                rd  = rnd[15:0];
            end
            bus.in_data   = rd;
            bus.out_ready = (int'($urandom_range(0, 99)) < ready_pct) ? 1'b1 : 1'b0;
            clear         = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
            step();
        end
        clear = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
